// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU for RV32I/RV64I plus M extension.
// Base ops and divide corner cases take one cycle; mul/div iterate XLEN times.
`timescale 1ns/1ps
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid,
  output logic            Ready,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [4:0]      ALUControl,
  output logic            ResultValid,
  input  logic            ResultReady,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opd_q;
  logic [2:0]        fn_q;
  logic              neg_q;

  logic            accept;
  logic            is_m;
  logic [2:0]      fn;
  logic            is_mul;
  logic            is_div;
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            neg_d;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic            go_long;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] sp_res;
  logic [XLEN-1:0] imm_res;

  logic              busy;
  logic              last;
  logic [XLEN:0]     mul_add;
  logic [2*XLEN-1:0] mul_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     rs;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nx;
  logic [XLEN-1:0]   q_nx;
  logic [XLEN-1:0]   q_f;
  logic [XLEN-1:0]   r_f;
  logic [XLEN-1:0]   div_res;
  logic [2*XLEN-1:0] iter_nx;
  logic [XLEN-1:0]   fin_res;

  logic            res_we;
  logic [XLEN-1:0] res_d;

  assign accept = Valid && Ready;
  assign is_m   = ALUControl[4];
  assign fn     = ALUControl[2:0];
  assign is_mul = is_m && !fn[2];
  assign is_div = is_m && fn[2];

  // MULH/MULHSU/DIV/REM treat A as signed; MULH/DIV/REM treat B as signed
  assign a_signed = is_m && (fn == 3'b001 || fn == 3'b010 ||
                             fn == 3'b100 || fn == 3'b110);
  assign b_signed = is_m && (fn == 3'b001 || fn == 3'b100 ||
                             fn == 3'b110);

  assign sa    = a_signed && SrcA[XLEN-1];
  assign sb    = b_signed && SrcB[XLEN-1];
  assign mag_a = sa ? -SrcA : SrcA;
  assign mag_b = sb ? -SrcB : SrcB;

  // remainder takes the dividend sign, everything else the product sign
  assign neg_d = (fn[2] && fn[1]) ? sa : (sa ^ sb);

  assign div_zero = (SrcB == '0);
  assign div_ovf  = !fn[0] && (SrcA == MIN) && (SrcB == '1);
  assign special  = is_div && (div_zero || div_ovf);
  assign go_long  = is_mul || (is_div && !special);

  assign shamt = SrcB[SW-1:0];

  always_comb begin
    base_res = '0;
    case (ALUControl)
      5'b00000: base_res = SrcA & SrcB;
      5'b00001: base_res = SrcA | SrcB;
      5'b00010: base_res = SrcA + SrcB;
      5'b00100: base_res = SrcA ^ SrcB;
      5'b00110: base_res = SrcA - SrcB;
      5'b00111: base_res = {{(XLEN-1){1'b0}},
                            ($signed(SrcA) < $signed(SrcB))};
      5'b01000: base_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      5'b01010: base_res = SrcA << shamt;
      5'b01011: base_res = SrcA >> shamt;
      5'b01100: base_res = $signed(SrcA) >>> shamt;
      default:  base_res = '0;
    endcase
  end

  always_comb begin
    sp_res = '0;
    unique case (1'b1)
      div_zero: sp_res = fn[1] ? SrcA : '1;
      default:  sp_res = fn[1] ? '0 : MIN;
    endcase
  end

  always_comb begin
    imm_res = '0;
    unique case (1'b1)
      !is_m:   imm_res = base_res;
      special: imm_res = sp_res;
      default: imm_res = '0;
    endcase
  end

  assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign last = (cnt_q == LAST);

  // shift-add: low half holds the multiplier, high half accumulates
  assign mul_add = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_nx  = {mul_add, acc_q[XLEN-1:1]};
  assign prod    = neg_q ? -mul_nx : mul_nx;
  assign mul_res = (fn_q == 3'b000) ? prod[XLEN-1:0]
                                    : prod[2*XLEN-1:XLEN];

  // restoring step: high half is the partial remainder
  assign rs      = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff    = rs - {1'b0, opd_q};
  assign ge      = !diff[XLEN];
  assign rem_nx  = ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
  assign q_nx    = {acc_q[XLEN-2:0], ge};
  assign q_f     = neg_q ? -q_nx : q_nx;
  assign r_f     = neg_q ? -rem_nx : rem_nx;
  assign div_res = fn_q[1] ? r_f : q_f;

  assign iter_nx = (state_q == ST_MUL) ? mul_nx : {rem_nx, q_nx};
  assign fin_res = (state_q == ST_MUL) ? mul_res : div_res;

  always_comb begin
    res_we = 1'b0;
    res_d  = '0;
    unique case (1'b1)
      accept && !go_long: begin
        res_we = 1'b1;
        res_d  = imm_res;
      end
      busy && last: begin
        res_we = 1'b1;
        res_d  = fin_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!go_long)    state_d = ST_DONE;
          else if (is_mul) state_d = ST_MUL;
          else             state_d = ST_DIV;
        end
      end
      ST_MUL:  if (last) state_d = ST_DONE;
      ST_DIV:  if (last) state_d = ST_DONE;
      ST_DONE: if (ResultReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Ready       = (state_q == ST_IDLE);
    ResultValid = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      fn_q      <= '0;
      neg_q     <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      if (accept) begin
        fn_q  <= fn;
        neg_q <= neg_d;
        cnt_q <= '0;
        if (is_mul) begin
          acc_q <= {{XLEN{1'b0}}, mag_b};
          opd_q <= mag_a;
        end else begin
          acc_q <= {{XLEN{1'b0}}, mag_a};
          opd_q <= mag_b;
        end
      end else if (busy) begin
        acc_q <= iter_nx;
        cnt_q <= cnt_q + CW'(1);
      end
      if (res_we) begin
        ALUResult <= res_d;
        Zero      <= (res_d == '0);
      end
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised execute-stage ALU for the next-generation RISC-V core. It covers the base RV32I/RV64I integer operations plus the M-extension multiply and divide operations. Operand width is set by `XLEN`. Base operations and divide special cases complete in one cycle; multiply and divide run an iterative datapath over `XLEN` cycles. It sits between the decode/register-read stage and writeback, using a valid/ready handshake on both sides so the core stalls while a long operation runs.

## Interface
- `XLEN`, default 32: operand/result width; legal values 8, 16, 32, 64; shift amount is `SrcB[$clog2(XLEN)-1:0]`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Valid`  in  1  request valid; the operation is accepted on a cycle where `Valid && Ready`.
- `Ready`  out  1  block can accept a request; high only in IDLE.
- `SrcA`  in  XLEN  operand A; sampled at accept.
- `SrcB`  in  XLEN  operand B; sampled at accept.
- `ALUControl`  in  5  operation select; sampled at accept.
- `ResultValid`  out  1  `ALUResult`/`Zero` are valid; held until consumed.
- `ResultReady`  in  1  consumer accepts the result on a cycle where `ResultValid && ResultReady`.
- `ALUResult`  out  XLEN  registered result.
- `Zero`  out  1  registered; 1 when `ALUResult == 0`.

## Operation
- **Base ops, `ALUControl[4]=0`:**
  - 00000 AND; 00001 OR; 00010 ADD; 00100 XOR; 00110 SUB.
  - 00111 SLT, signed compare; 01000 SLTU, unsigned compare.
  - 01010 SLL; 01011 SRL; 01100 SRA, arithmetic.
  - Any other base code: result 0.
- **M ops, `ALUControl[4]=1`, low 3 bits = RISC-V funct3:**
  - 000 MUL, low XLEN bits of the product.
  - 001 MULH, signed×signed, high half.
  - 010 MULHSU, signed A × unsigned B, high half.
  - 011 MULHU, high half.
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- **FSM states:** IDLE, MUL, DIV, DONE.
  - IDLE: on accept of a base op or a divide special case, compute and register the result, then go to DONE.
  - IDLE: on accept of a multiply, go to MUL; on accept of a divide, go to DIV.
  - MUL: radix-2 shift-add over a 2·XLEN-bit accumulator.
  - DIV: restoring division over operand magnitudes.
  - MUL and DIV each run exactly XLEN iterations, tracked by a `$clog2(XLEN)+1`-bit counter, then go to DONE.
  - DONE: `ResultValid=1`. Go to IDLE on `ResultReady`.
- **Sign handling:**
  - Signed operands are converted to magnitudes at accept.
  - The final result is conditionally negated in the last iteration cycle.
  - The sign of MULH/MULHSU follows the operand signs.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- **Divide special cases:** resolved in IDLE, 1-cycle latency.
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return SrcA.
  - Signed overflow (A = most negative, B = −1): DIV returns the most-negative value; REM returns 0.
- **Ignored inputs:**
  - `Valid` while `Ready=0` is ignored. The requester must hold the request.
  - Operand changes after accept have no effect.
- `Zero` is computed from the value being registered into `ALUResult`.

## Timing
- **Reset values (cycle after `reset` high):** IDLE, `Ready=1`, `ResultValid=0`, `ALUResult=0`, `Zero=0`, counter 0.
- **Reset mid-operation:** aborts MUL/DIV/DONE. The pending result is discarded and never presented.
- **Latency, accept edge to `ResultValid`:**
  - Base ops and divide special cases: 1 cycle.
  - MUL/DIV: XLEN+1 cycles (32-bit: 33).
- **Result hold:** `ResultValid` stays high and `ALUResult`/`Zero` stay stable until the `ResultReady` cycle.
- **Back-to-back:**
  - `Ready` rises the cycle after the result is consumed.
  - No accept occurs in the same cycle as consumption.
  - Peak throughput is therefore one base op per 2 cycles.
- **During MUL/DIV/DONE:** `Ready=0`.

## Test plan
- **Base-op latency:**
  - ADD 0x7FFFFFFF+0x00000001, `ResultReady=1` → `ResultValid` 1 cycle after accept, `ALUResult=0x80000000`, `Zero=0`.
  - SUB 5−5 → 0, `Zero=1`.
- **Signed vs unsigned compare:** SLT 0xFFFFFFFF vs 0x1 → 1; SLTU same operands → 0.
- **Signed multiply:**
  - MULH 0x80000000×0x80000000 → 0x40000000, `ResultValid` exactly 33 cycles after accept.
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- **Division sign rules:** DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- **Special cases:** DIVU x/0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- **Backpressure and reset:**
  - Hold `ResultReady=0` for 10 cycles → result and `Zero` stable, `Ready=0`.
  - Assert `reset` at iteration 16 of a DIV → next cycle `Ready=1`, `ResultValid=0`, and no stale result appears afterwards.
